imem_test_sequencer: RTL and testbench
======================================

Name: imem_test_sequencer

Overview:
- Sequences one CPU test run: streams a program image into instruction memory while the core is held, releases the core, then watches the fetch PC for the pass signature or a timeout.
- Sits beside cpu_top. Drives the instruction-memory write port and the core hold line, and samples pc_current_s1.
- Replaces preload-and-poll in simulation and makes the same flow usable on FPGA from a loader stream.

Parameters:
- ADDR_W, 10, word-address width of instruction memory. Depth is 2**ADDR_W words.
- CNT_W, 32, width of the run-cycle counter and max_cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- load_start  in  1  single-cycle pulse that starts a load-and-run sequence
- load_len  in  ADDR_W+1  number of 32-bit words to load; sampled with load_start
- load_valid  in  1  loader word valid
- load_data  in  32  loader word
- load_ready  out  1  sequencer accepts a word
- imem_we  out  1  instruction-memory write enable
- imem_waddr  out  ADDR_W  word address
- imem_wdata  out  32  write data
- cpu_hold  out  1  holds the core in reset/stall while high
- cpu_pc  in  32  current fetch PC (pc_current_s1)
- pass_addr  in  32  PC of the pass target; sampled with load_start
- last_addr  in  32  PC that must immediately precede pass_addr; sampled with load_start
- max_cycles  in  CNT_W  run timeout in cycles; sampled with load_start
- status  out  2  0 IDLE/BUSY, 1 PASS, 2 TIMEOUT, 3 ERR
- done  out  1  high while in a terminal state
- cycle_cnt  out  CNT_W  core cycles elapsed in RUN

Behaviour:
- Reset values: state IDLE, cpu_hold=1, load_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, status=0, done=0, cycle_cnt=0.
- IDLE, on load_start:
  - Latch load_len, pass_addr, last_addr and max_cycles.
  - load_len > 2**ADDR_W: go to ERR.
  - load_len == 0: go to RUN.
  - Otherwise: go to LOAD with word_cnt=0.
- LOAD:
  - load_ready=1.
  - Each load_valid&load_ready handshake writes on the next cycle (registered): imem_we=1, imem_waddr=word_cnt, imem_wdata=load_data; word_cnt then increments.
  - Back-to-back handshakes give one write per cycle.
  - load_ready drops in the cycle after the final handshake. The next state is DRAIN, where the last write issues.
- DRAIN: one cycle, then RUN.
- RUN entry:
  - cpu_hold=0 from the first RUN cycle.
  - cycle_cnt=0.
  - prev_pc = 32'hFFFF_FFFF (sentinel, so no false match on the first cycle).
- RUN, each cycle:
  - cycle_cnt += 1 (saturates at all-ones).
  - prev_pc <= cpu_pc.
  - If cpu_pc==pass_addr and prev_pc==last_addr: go to PASS.
  - Else if cycle_cnt+1 == max_cycles: go to TIMEOUT.
  - If both occur in the same cycle, PASS wins.
  - max_cycles==0 means no timeout.
- PASS / TIMEOUT / ERR:
  - cpu_hold=1, done=1, status per the encoding above.
  - cycle_cnt frozen.
  - Held until load_start, which restarts via the IDLE rules (done and status clear in the same cycle).
- load_start while in LOAD, DRAIN or RUN is ignored.
- Asynchronous reset mid-LOAD or mid-RUN returns to reset values immediately. Writes already issued to memory are not undone.
- imem_we is never high outside LOAD/DRAIN.

Optional Feature:
- Macro IMEM_LOAD_CHECKSUM_EN.
- Defined:
  - Extra output load_sum (32): wrap-around mod 2^32 sum of every accepted load_data.
  - Cleared on load_start and frozen after DRAIN.
  - If load_sum differs from a sum_expect input (32, sampled with load_start), DRAIN goes to ERR instead of RUN and the core is never released.
- Undefined: neither port exists and DRAIN always goes to RUN.

Decomposition:
- Package cpu_test_pkg:
  - state enum: IDLE, LOAD, DRAIN, RUN, PASS, TIMEOUT, ERR.
  - status encoding constants: ST_BUSY, ST_PASS, ST_TIMEOUT, ST_ERR.
  - PC_SENTINEL constant.
- Sub-module pc_pass_detect:
  - Contains the prev_pc register and the last_addr→pass_addr transition compare, with a clear input driven on RUN entry.
  - Reused by the standalone testbench monitor.

Test Plan:
- load_len=4, words 0x00000013 ×4 streamed back-to-back → imem_we on 4 consecutive cycles at waddr 0..3; load_ready low after the 4th handshake; cpu_hold falls 2 cycles after the last handshake.
- load_valid toggled every other cycle, load_len=3 → exactly 3 writes with correct data; no writes in gap cycles.
- RUN with pass_addr=0x394, last_addr=0x37C; drive cpu_pc 0x37C then 0x394 at cycle 10 → status=1, done=1, cpu_hold=1, cycle_cnt=10.
- cpu_pc reaches 0x394 from 0x380 (not last_addr) → no pass. With max_cycles=2000 → status=2 at cycle_cnt=2000.
- load_len=2**ADDR_W+1 → status=3 next cycle, no imem_we, cpu_hold stays 1. Then load_start with load_len=0 → RUN immediately.
- rst_n pulsed low mid-LOAD after 2 of 5 words → all outputs at reset values asynchronously. With IMEM_LOAD_CHECKSUM_EN: words 1,2,3 with sum_expect=7 → ERR; with sum_expect=6 → RUN.

Source files
------------

// File: rtl/imem_test_sequencer_pkg.sv
// Shared types and constants for the instruction-memory test sequencer.
// Package name is cpu_test_pkg so the detector and standalone monitors can share it.
package cpu_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        RUN,
        PASS,
        TIMEOUT,
        ERR
    } seq_state_t;

    localparam logic [1:0] ST_BUSY    = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_ERR     = 2'd3;

    // prev_pc value that no real fetch PC is expected to follow
    localparam logic [31:0] PC_SENTINEL = 32'hFFFF_FFFF;

    function automatic logic is_terminal(input seq_state_t s);
        return (s == PASS) || (s == TIMEOUT) || (s == ERR);
    endfunction

    function automatic logic [1:0] status_of(input seq_state_t s);
        logic [1:0] st;
        case (s)
            PASS:    st = ST_PASS;
            TIMEOUT: st = ST_TIMEOUT;
            ERR:     st = ST_ERR;
            default: st = ST_BUSY;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/imem_test_sequencer_if.sv
// Loader stream plus instruction-memory write port of the test sequencer.
// master = sequencer side, slave = loader / memory side.
interface imem_test_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    modport master (
        input  load_valid, load_data,
        output load_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        output load_valid, load_data,
        input  load_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_test_sequencer_pc_pass_detect.sv
// Detects the last_addr -> pass_addr fetch transition that signals a passing test.
// clear reloads the sentinel so the first cycle after clear can never match.
module pc_pass_detect
    import cpu_test_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] cpu_pc,
    input  logic [31:0] pass_addr,
    input  logic [31:0] last_addr,
    output logic        hit
);
    logic [31:0] prev_pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_pc_reg <= PC_SENTINEL;
        end else if (clear) begin
            prev_pc_reg <= PC_SENTINEL;
        end else if (enable) begin
            prev_pc_reg <= cpu_pc;
        end
    end

    assign hit = (cpu_pc == pass_addr) && (prev_pc_reg == last_addr);

endmodule

// File: rtl/imem_test_sequencer.sv
// Loads a program image into instruction memory, releases the core and watches for
// the pass signature or a timeout. Optional load checksum: define IMEM_LOAD_CHECKSUM_EN.
module imem_test_sequencer
    import cpu_test_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [ADDR_W:0]       load_len,
    imem_test_sequencer_if.master mem_bus,
    output logic                  cpu_hold,
    input  logic [31:0]           cpu_pc,
    input  logic [31:0]           pass_addr,
    input  logic [31:0]           last_addr,
    input  logic [CNT_W-1:0]      max_cycles,
`ifdef IMEM_LOAD_CHECKSUM_EN
    input  logic [31:0]           sum_expect,
    output logic [31:0]           load_sum,
`endif
    output logic [1:0]            status,
    output logic                  done,
    output logic [CNT_W-1:0]      cycle_cnt
);
    localparam logic [ADDR_W:0]  DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  ONE_W   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_t        state_reg, state_next;
    logic [ADDR_W:0]   len_reg;
    logic [ADDR_W:0]   word_cnt_reg;
    logic [31:0]       pass_reg;
    logic [31:0]       last_reg;
    logic [CNT_W-1:0]  max_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [31:0]       wdata_reg;

    logic load_ready_int;
    logic start_ok;
    logic hs;
    logic last_word;
    logic run_entry;
    logic pass_hit;
    logic checksum_bad;

    assign load_ready_int = (state_reg == LOAD);
    assign start_ok       = load_start && ((state_reg == IDLE) || is_terminal(state_reg));
    assign hs             = mem_bus.load_valid && load_ready_int;
    assign last_word      = hs && ((word_cnt_reg + ONE_W) == len_reg);
    assign run_entry      = (state_next == RUN) && (state_reg != RUN);

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] sum_reg;
    logic [31:0] sum_exp_reg;

    // Sum only moves on accepted words, so it is naturally frozen once DRAIN is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg     <= '0;
            sum_exp_reg <= '0;
        end else if (start_ok) begin
            sum_reg     <= '0;
            sum_exp_reg <= sum_expect;
        end else if (hs) begin
            sum_reg     <= sum_reg + mem_bus.load_data;
        end
    end

    assign checksum_bad = (sum_reg != sum_exp_reg);
    assign load_sum     = sum_reg;
`else
    assign checksum_bad = 1'b0;
`endif

    pc_pass_detect u_pass_detect (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (run_entry),
        .enable    (state_reg == RUN),
        .cpu_pc    (cpu_pc),
        .pass_addr (pass_reg),
        .last_addr (last_reg),
        .hit       (pass_hit)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, PASS, TIMEOUT, ERR: begin
                if (load_start) begin
                    if (load_len > DEPTH) begin
                        state_next = ERR;
                    end else if (load_len == '0) begin
                        state_next = RUN;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (last_word) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = checksum_bad ? ERR : RUN;
            end
            RUN: begin
                // Pass is checked first so it wins over a same-cycle timeout
                if ((state_reg == RUN) && pass_hit) begin
                    state_next = PASS;
                end else if ((max_reg != '0) && ((cnt_reg + ONE_CNT) == max_reg)) begin
                    state_next = TIMEOUT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            word_cnt_reg <= '0;
            pass_reg     <= '0;
            last_reg     <= '0;
            max_reg      <= '0;
            cnt_reg      <= '0;
            we_reg       <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg <= state_next;
            we_reg    <= hs;
            if (start_ok) begin
                len_reg      <= load_len;
                pass_reg     <= pass_addr;
                last_reg     <= last_addr;
                max_reg      <= max_cycles;
                word_cnt_reg <= '0;
            end else if (hs) begin
                waddr_reg    <= word_cnt_reg[ADDR_W-1:0];
                wdata_reg    <= mem_bus.load_data;
                word_cnt_reg <= word_cnt_reg + ONE_W;
            end
            if (run_entry) begin
                cnt_reg <= '0;
            end else if ((state_reg == RUN) && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + ONE_CNT;
            end
        end
    end

    assign mem_bus.load_ready = load_ready_int;
    assign mem_bus.imem_we    = we_reg;
    assign mem_bus.imem_waddr = waddr_reg;
    assign mem_bus.imem_wdata = wdata_reg;
    assign cpu_hold           = (state_reg != RUN);
    assign status             = status_of(state_reg);
    assign done               = is_terminal(state_reg);
    assign cycle_cnt          = cnt_reg;

endmodule

// File: tb/tb_imem_test_sequencer.sv
// Self-checking bench for imem_test_sequencer: decode table, directed multi-cycle
// sequences and randomized load/run transactions against a transaction-level model.
module tb_imem_test_sequencer;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 32;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] SENT = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              cpu_hold;
    logic [31:0]       cpu_pc;
    logic [31:0]       pass_addr;
    logic [31:0]       last_addr;
    logic [CNT_W-1:0]  max_cycles;
    logic [1:0]        status;
    logic              done;
    logic [CNT_W-1:0]  cycle_cnt;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0]       sum_expect;
    logic [31:0]       load_sum;
`endif

    imem_test_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    imem_test_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_len   (load_len),
        .mem_bus    (bus),
        .cpu_hold   (cpu_hold),
        .cpu_pc     (cpu_pc),
        .pass_addr  (pass_addr),
        .last_addr  (last_addr),
        .max_cycles (max_cycles),
`ifdef IMEM_LOAD_CHECKSUM_EN
        .sum_expect (sum_expect),
        .load_sum   (load_sum),
`endif
        .status     (status),
        .done       (done),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state carried across transactions
    int          m_cnt = 0;
    logic [31:0] words[$];
    logic [31:0] pc_q[$];
    bit          rand_pc = 1'b0;

    typedef struct {
        logic [ADDR_W:0] len;
        logic [1:0]      st;
        logic            rdy;
        logic            hold;
        logic            dn;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_hold"},   cpu_hold, 1);
        chk({tag, "_ready"},  bus.load_ready, 0);
        chk({tag, "_we"},     bus.imem_we, 0);
        chk({tag, "_waddr"},  bus.imem_waddr, 0);
        chk({tag, "_wdata"},  bus.imem_wdata, 0);
        chk({tag, "_status"}, status, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_cnt"},    cycle_cnt, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
    endtask

    // One load-and-run transaction. Called and returns on a falling edge.
    // phase: 0 loading, 1 draining, 2 running, 3 finished
    task automatic do_run(input int len, input bit sparse, input logic [31:0] pa,
                          input logic [31:0] la, input logic [CNT_W-1:0] maxc,
                          input int sum_err, output int res);
        int          acc;
        int          phase;
        int          bound;
        bit          finished;
        bit          pend_we;
        logic [ADDR_W-1:0] pend_a;
        logic [31:0] pend_d;
        logic [31:0] prev;
        logic [31:0] pc;
`ifdef IMEM_LOAD_CHECKSUM_EN
        logic [31:0] sum;
`endif
        if (len <= DEPTH) begin
            while (words.size() < len) words.push_back($urandom);
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        sum = 0;
        for (int i = 0; i < len && len <= DEPTH; i++) sum += words[i];
        sum_expect = sum + sum_err;
`endif
        load_start = 1'b1;
        load_len   = len[ADDR_W:0];
        pass_addr  = pa;
        last_addr  = la;
        max_cycles = maxc;
        @(negedge clk);
        load_start     = 1'b0;
        bus.load_valid = 1'b0;
        res = 0;
        if (len > DEPTH) begin
            chk("err_status", status, 3);
            chk("err_done", done, 1);
            chk("err_hold", cpu_hold, 1);
            chk("err_ready", bus.load_ready, 0);
            chk("err_we", bus.imem_we, 0);
            chk("err_cnt", cycle_cnt, m_cnt);
            res = 3;
        end else begin
            acc = 0; pend_we = 0; pend_a = '0; pend_d = '0; prev = SENT; finished = 0;
            phase = (len == 0) ? 2 : 0;
            if (phase == 2) m_cnt = 0;
            bound = 3 * len + 40 + ((maxc == 0) ? 200 : int'(maxc));
            for (int cyc = 0; cyc < bound && !finished; cyc++) begin
                chk("ready", bus.load_ready, phase == 0);
                chk("we", bus.imem_we, pend_we);
                if (pend_we) begin
                    chk("waddr", bus.imem_waddr, pend_a);
                    chk("wdata", bus.imem_wdata, pend_d);
                end
                chk("hold", cpu_hold, phase != 2);
                chk("busy_status", status, 0);
                chk("busy_done", done, 0);
                if (phase == 2) chk("run_cnt", cycle_cnt, m_cnt);
                pend_we = 0;
                bus.load_valid = 1'b0;
                case (phase)
                    0: begin
                        bus.load_valid = sparse ? (cyc % 2 == 0) : 1'b1;
                        bus.load_data  = bus.load_valid ? words[acc] : $urandom;
                        if (bus.load_valid) begin
                            pend_we = 1; pend_a = acc[ADDR_W-1:0]; pend_d = words[acc];
                            acc++;
                            if (acc == len) phase = 1;
                        end
                    end
                    1: begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                        if (sum_err != 0) begin phase = 3; res = 3; end else
`endif
                        begin phase = 2; m_cnt = 0; end
                    end
                    2: begin
                        if (pc_q.size() > 0) pc = pc_q.pop_front();
                        else if (rand_pc) begin
                            case ($urandom_range(3))
                                0: pc = la;
                                1: pc = pa;
                                2: pc = 32'h100;
                                default: pc = 32'h104;
                            endcase
                        end else pc = 32'h100;
                        cpu_pc = pc;
                        m_cnt++;
                        if (pc == pa && prev == la) begin phase = 3; res = 1; end
                        else if (maxc != 0 && m_cnt == int'(maxc)) begin phase = 3; res = 2; end
                        prev = pc;
                    end
                    default: ;
                endcase
                @(negedge clk);
                if (phase == 3) finished = 1;
            end
            chk("run_bound", finished, 1);
            chk("end_status", status, res);
            chk("end_done", done, 1);
            chk("end_hold", cpu_hold, 1);
            chk("end_ready", bus.load_ready, 0);
            chk("end_we", bus.imem_we, 0);
            chk("end_cnt", cycle_cnt, m_cnt);
`ifdef IMEM_LOAD_CHECKSUM_EN
            chk("end_sum", load_sum, sum);
`endif
        end
        $display("run len=%0d sparse=%0d max=%0d -> result=%0d cnt=%0d", len, sparse, maxc, res, m_cnt);
        words.delete();
        pc_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst_n = 1'b0; load_start = 1'b0; load_len = '0; cpu_pc = 32'h0;
        pass_addr = '0; last_addr = '0; max_cycles = '0;
        bus.load_valid = 1'b0; bus.load_data = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        sum_expect = '0;
`endif
        vecs[0] = '{11'd0,    2'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{11'd1,    2'd0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{11'd1024, 2'd0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{11'd1025, 2'd3, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{11'd2047, 2'd3, 1'b0, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;

        // IDLE decode of load_len
        for (int i = 0; i < 5; i++) begin
            do_reset();
            load_start = 1'b1; load_len = vecs[i].len; max_cycles = '0;
            @(negedge clk);
            load_start = 1'b0;
            chk("tbl_status", status, vecs[i].st);
            chk("tbl_ready", bus.load_ready, vecs[i].rdy);
            chk("tbl_hold", cpu_hold, vecs[i].hold);
            chk("tbl_done", done, vecs[i].dn);
            chk("tbl_we", bus.imem_we, 0);
            $display("vec len=%0d status=%0d ready=%0d hold=%0d", vecs[i].len, status, bus.load_ready, cpu_hold);
        end

        // load_start ignored while running
        do_reset();
        cpu_pc = 32'h100; pass_addr = 32'h394; last_addr = 32'h37C;
        load_start = 1'b1; load_len = '0; max_cycles = '0;
        @(negedge clk);
        load_len = 11'd1025;
        @(negedge clk);
        load_start = 1'b0;
        chk("ign_run_hold", cpu_hold, 0);
        chk("ign_run_status", status, 0);
        chk("ign_run_cnt", cycle_cnt, 1);
        $display("ignore-in-run hold=%0d cnt=%0d", cpu_hold, cycle_cnt);

        // load_start ignored while loading
        do_reset();
        load_start = 1'b1; load_len = 11'd3;
        @(negedge clk);
        load_len = '0;
        @(negedge clk);
        load_start = 1'b0;
        chk("ign_load_ready", bus.load_ready, 1);
        chk("ign_load_hold", cpu_hold, 1);
        $display("ignore-in-load ready=%0d hold=%0d", bus.load_ready, cpu_hold);

        // asynchronous reset after 2 of 5 words
        do_reset();
        load_start = 1'b1; load_len = 11'd5;
        @(negedge clk);
        load_start = 1'b0; bus.load_valid = 1'b1; bus.load_data = 32'hA5A5_0001;
        @(negedge clk);
        bus.load_data = 32'hA5A5_0002;
        @(negedge clk);
        bus.load_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async");
        $display("async reset mid-load hold=%0d we=%0d", cpu_hold, bus.imem_we);
        @(negedge clk);
        rst_n = 1'b1; m_cnt = 0;

        // back-to-back load of 4 NOPs, pass on the 10th run cycle
        do_reset();
        rand_pc = 1'b0;
        repeat (4) words.push_back(32'h0000_0013);
        repeat (8) pc_q.push_back(32'h100);
        pc_q.push_back(32'h37C);
        pc_q.push_back(32'h394);
        do_run(4, 1'b0, 32'h394, 32'h37C, 0, 0, r);
        chk("pass_status", status, 1);
        chk("pass_cnt", cycle_cnt, 10);

        // sparse valid, pass address reached from the wrong predecessor -> timeout
        for (int i = 0; i < 4; i++) begin
            pc_q.push_back(32'h380);
            pc_q.push_back(32'h394);
        end
        do_run(3, 1'b1, 32'h394, 32'h37C, 2000, 0, r);
        chk("to_status", status, 2);
        chk("to_cnt", cycle_cnt, 2000);

        // oversize load errors, then a zero-length load runs immediately
        do_run(DEPTH + 1, 1'b0, 32'h394, 32'h37C, 0, 0, r);
        pc_q.push_back(32'h37C);
        pc_q.push_back(32'h394);
        do_run(0, 1'b0, 32'h394, 32'h37C, 0, 0, r);
        chk("zero_len_cnt", cycle_cnt, 2);

`ifdef IMEM_LOAD_CHECKSUM_EN
        words.push_back(32'd1); words.push_back(32'd2); words.push_back(32'd3);
        do_run(3, 1'b0, 32'h394, 32'h37C, 20, 1, r);
        chk("cks_bad_status", status, 3);
        words.push_back(32'd1); words.push_back(32'd2); words.push_back(32'd3);
        do_run(3, 1'b0, 32'h394, 32'h37C, 20, 0, r);
        chk("cks_ok_status", status, 2);
`endif

        // randomized transactions, each starting from the previous terminal state
        rand_pc = 1'b1;
        for (int i = 0; i < 14; i++) begin
            logic [31:0] pa, la;
            int sum_err;
            pa = ($urandom_range(1) == 0) ? 32'h104 : 32'h394;
            case ($urandom_range(2))
                0: la = 32'h100;
                1: la = 32'h104;
                default: la = 32'h37C;
            endcase
            sum_err = 0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            if ($urandom_range(3) == 0) sum_err = $urandom_range(1, 9);
`endif
            do_run($urandom_range(0, 12), 1'($urandom_range(1)), pa, la,
                   CNT_W'($urandom_range(1, 40)), sum_err, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
